bpm_uart_reporter: RTL and testbench
====================================

# bpm_uart_reporter

Downstream consumer of the BPM calculator: captures each `bpm_value` offered with `bpm_valid` and acknowledges it with `bpm_copied`. It converts the value to three zero-padded ASCII decimal digits and transmits `ddd\r\n` as 8N1 UART frames on `uart_tx`. It is the last digital stage before the board-level UART pin.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 115200: UART bit rate.
- `CLKS_PER_BIT`, CLK_FREQ/BAUD (integer division, 868 at defaults): cycles per UART bit. Elaboration error if < 2.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  enables capture of new values; does not abort a frame already in progress.
- `bpm_value`  in  8  BPM from the calculator, unsigned 0..255.
- `bpm_valid`  in  1  level; calculator holds it high until `bpm_copied` is seen.
- `bpm_copied`  out  1  one-cycle acknowledge of capture.
- `uart_tx`  out  1  serial line, idle high.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of the LF stop bit.

## Operation
- States: IDLE → CONV → START → DATA → STOP. STOP returns to START for the next character, or to IDLE after character index 4.
- IDLE: on an edge with `en && bpm_valid`:
  - latch `bpm_value` into `rem`, clear `hund` and `tens`;
  - register `bpm_copied`=1 for the next cycle only;
  - go to CONV.
- CONV, one step per cycle:
  - if `rem` ≥ 100: `rem` −= 100, `hund`++;
  - else if `rem` ≥ 10: `rem` −= 10, `tens`++;
  - else: `ones` = `rem`, set char index to 0, go to START.
  - Widths: `rem` 8 bits, `hund` 2 bits, `tens` 4 bits, `ones` 4 bits.
- Character sequence by index 0..4: `0x30+hund`, `0x30+tens`, `0x30+ones`, `0x0D`, `0x0A`. Leading zeros are always sent.
- Each character is 10 bits, each held exactly CLKS_PER_BIT cycles:
  - START: `uart_tx`=0;
  - DATA: bits 0..7, LSB first;
  - STOP: `uart_tx`=1.
- `uart_tx` is a register output and must never glitch.
- `bpm_valid` while busy: ignored. Because the calculator holds valid, the value is captured on the first IDLE edge afterwards. Values are never queued or merged.
- `en` falling mid-frame: the frame completes normally; no capture happens afterwards while `en` is low.
- `rst` asserted at any point, including mid-bit:
  - `uart_tx`=1, `busy`=0, `bpm_copied`=0, `frame_done`=0;
  - state IDLE; all counters and digit registers 0.
  - These take effect immediately, without a clock edge.

## Timing
- Reset values: `uart_tx`=1, `busy`=0, `bpm_copied`=0, `frame_done`=0.
- Capture edge E: `bpm_copied` is high in cycle E+1 only, and `busy` rises in E+1.
- CONV lasts `hund`+`tens`+1 cycles. `uart_tx` falls (start bit) in the first cycle after CONV.
- Frame length from start-bit fall to end of the last stop bit: 50·CLKS_PER_BIT cycles.
- `frame_done`=1 and `busy`=0 in the same cycle, which is the first cycle after the last LF stop-bit cycle.
- Earliest next capture is the edge at the end of that cycle. There is no idle gap between characters.
- `busy` and `bpm_copied` are never high because of the same value twice.

## Structure
- Package `bpm_uart_pkg` holds:
  - the state encoding (IDLE, CONV, START, DATA, STOP);
  - `ASCII_ZERO`=8'h30, `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A;
  - `FRAME_CHARS`=5.
- Sub-module `uart_tx_byte` is the byte serializer, parameterised by CLKS_PER_BIT:
  - ports `clk`, `rst`, `start`, `data[7:0]`, `tx`, `done`;
  - contains the baud counter and the 4-bit bit index.
- The top level contains the capture/handshake logic, CONV, character index and character select, and instantiates `uart_tx_byte`.

## Test plan
All scenarios use CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16) unless stated.
- Reset then idle, `bpm_valid`=0 for 1000 cycles → `uart_tx` stays 1, `busy`=0, no `bpm_copied`.
- `bpm_value`=72 with valid → exactly one `bpm_copied` pulse; CONV takes 8 cycles; decoded line bytes are 0x30,0x37,0x32,0x0D,0x0A; `frame_done` arrives 800 cycles after the start-bit fall.
- Boundary values 0, 9, 10, 99, 100, 199, 200, 255 → decoded as "000", "009", "010", "099", "100", "199", "200", "255", each followed by CR LF.
- Valid held high while busy with a new value 120 → no `bpm_copied` until the cycle after `frame_done` edge; next line is "120\r\n"; no gap and no duplicate acknowledge.
- `en` dropped during the tens digit → full line still sent; a later valid is not acknowledged until `en`=1.
- `rst` pulsed mid data bit → `uart_tx`=1 asynchronously, `busy`=0; after release a fresh value 60 transmits cleanly. Repeat at defaults (868 cycles per bit) for one line.

Source files
------------

// File: rtl/bpm_uart_pkg.sv
// Shared definitions for the BPM UART reporter.
//   state_t     : controller/serializer state encoding (IDLE, CONV, START, DATA, STOP)
//   ASCII_*     : character codes used to build a "ddd\r\n" line
//   FRAME_CHARS : number of characters in one line
package bpm_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int FRAME_CHARS = 5;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset (line returns idle-high at once)
//   start : load data and begin a character; accepted when idle or in the
//           last cycle of a stop bit, so characters can run back to back
//   data  : byte to send, LSB first
//   tx    : registered serial output, idle high
//   done  : high during the last cycle of the stop bit
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  import bpm_uart_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_t          phase, phase_n;
  logic [CW-1:0]   baud_cnt, baud_n;
  logic [3:0]      bit_idx, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            tx_q, tx_n;
  logic            bit_end;

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign done    = (phase == STOP) && bit_end;
  assign tx      = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      phase    <= phase_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
    end
  end

  // tx_n is always the level of the bit that starts at the next edge, so
  // the line is driven straight from a flop and cannot glitch.
  always_comb begin
    phase_n = phase;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    if (start && (phase == IDLE || done)) begin
      phase_n = START;
      baud_n  = '0;
      bit_n   = '0;
      shreg_n = data;
      tx_n    = 1'b0;
    end else if (phase != IDLE) begin
      if (!bit_end) begin
        baud_n = baud_cnt + 1'b1;
      end else begin
        baud_n = '0;
        case (phase)
          START: begin
            phase_n = DATA;
            tx_n    = shreg[0];
            shreg_n = {1'b0, shreg[7:1]};
          end
          DATA: begin
            if (bit_idx == 4'd7) begin
              phase_n = STOP;
              tx_n    = 1'b1;
            end else begin
              bit_n   = bit_idx + 4'd1;
              tx_n    = shreg[0];
              shreg_n = {1'b0, shreg[7:1]};
            end
          end
          default: begin
            phase_n = IDLE;
            tx_n    = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/bpm_uart_reporter.sv
// Captures a BPM value from the calculator, converts it to three ASCII
// decimal digits and sends "ddd\r\n" as 8N1 UART characters.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : allows capture of new values (a line in flight always completes)
//   bpm_value  : unsigned BPM, 0..255
//   bpm_valid  : level request, held by the calculator until bpm_copied
//   bpm_copied : one-cycle capture acknowledge
//   uart_tx    : serial line, idle high
//   busy       : high while a value is being converted or transmitted
//   frame_done : one-cycle pulse after the final LF stop bit
module bpm_uart_reporter #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] bpm_value,
  input  logic       bpm_valid,
  output logic       bpm_copied,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_done
);
  import bpm_uart_pkg::*;

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("bpm_uart_reporter: CLKS_PER_BIT must be at least 2");
  end

  localparam logic [2:0] LAST_IDX = 3'(FRAME_CHARS - 1);

  state_t      state, state_n;
  logic [7:0]  rem, rem_n;
  logic [1:0]  hund, hund_n;
  logic [3:0]  tens, tens_n;
  logic [3:0]  ones, ones_n;
  logic [2:0]  char_idx, idx_n;
  logic        copied_q, copied_n;
  logic        fdone_q, fdone_n;
  logic        tx_start, tx_done;
  logic [7:0]  tx_data;

  function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [1:0] h,
                                         input logic [3:0] t, input logic [3:0] o);
    case (idx)
      3'd0:    return ASCII_ZERO + {6'd0, h};
      3'd1:    return ASCII_ZERO + {4'd0, t};
      3'd2:    return ASCII_ZERO + {4'd0, o};
      3'd3:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      hund     <= '0;
      tens     <= '0;
      ones     <= '0;
      char_idx <= '0;
      copied_q <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      hund     <= hund_n;
      tens     <= tens_n;
      ones     <= ones_n;
      char_idx <= idx_n;
      copied_q <= copied_n;
      fdone_q  <= fdone_n;
    end
  end

  // The controller sits in START for the whole line; the per-character
  // START/DATA/STOP bit phases are tracked inside the serializer.
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    hund_n   = hund;
    tens_n   = tens;
    ones_n   = ones;
    idx_n    = char_idx;
    copied_n = 1'b0;
    fdone_n  = 1'b0;
    tx_start = 1'b0;
    case (state)
      IDLE: begin
        if (en && bpm_valid) begin
          rem_n    = bpm_value;
          hund_n   = '0;
          tens_n   = '0;
          copied_n = 1'b1;
          state_n  = CONV;
        end
      end
      CONV: begin
        // Repeated subtraction: one hundred or one ten removed per cycle.
        if (rem >= 8'd100) begin
          rem_n  = rem - 8'd100;
          hund_n = hund + 2'd1;
        end else if (rem >= 8'd10) begin
          rem_n  = rem - 8'd10;
          tens_n = tens + 4'd1;
        end else begin
          ones_n   = rem[3:0];
          idx_n    = '0;
          tx_start = 1'b1;
          state_n  = START;
        end
      end
      default: begin
        if (tx_done) begin
          if (char_idx == LAST_IDX) begin
            state_n = IDLE;
            fdone_n = 1'b1;
          end else begin
            idx_n    = char_idx + 3'd1;
            tx_start = 1'b1;
          end
        end
      end
    endcase
  end

  // The hundreds digit is final in the last CONV cycle and the ones digit is
  // registered well before character 2 is loaded, so select on idx_n.
  assign tx_data = char_at(idx_n, hund, tens, ones);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (tx_data),
    .tx    (uart_tx),
    .done  (tx_done)
  );

  assign busy       = (state != IDLE);
  assign bpm_copied = copied_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_bpm_uart_reporter.sv
module tb_bpm_uart_reporter;

  localparam int CPB   = 16;
  localparam int CPB_D = 868;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [7:0] value_m = 8'd0, value_d = 8'd0;
  logic       valid_m = 1'b0, valid_d = 1'b0;
  logic       copied_m, tx_m, busy_m, fd_m;
  logic       copied_d, tx_d, busy_d, fd_d;

  bpm_uart_reporter #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .en(en), .bpm_value(value_m), .bpm_valid(valid_m),
    .bpm_copied(copied_m), .uart_tx(tx_m), .busy(busy_m), .frame_done(fd_m)
  );

  bpm_uart_reporter dut_def (
    .clk(clk), .rst(rst), .en(en), .bpm_value(value_d), .bpm_valid(valid_d),
    .bpm_copied(copied_d), .uart_tx(tx_d), .busy(busy_d), .frame_done(fd_d)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the 16-cycle/bit instance -------
  int         cyc = 0;
  bit         have = 0;
  int         copy_c = 0, start_c = 0, end_c = 0;
  logic [7:0] ln [5];

  function automatic bit mbusy(input int t);
    return have && t >= copy_c && t < end_c;
  endfunction

  // Line level k cycles after the start-bit fall.
  function automatic logic line_bit(input int k);
    int ch, b;
    ch = k / (10 * CPB);
    b  = (k % (10 * CPB)) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ln[ch][b-1];
  endfunction

  initial forever begin
    int v;
    @(posedge clk);
    cyc++;
    if (rst) begin
      have = 0;
    end else if (en && valid_m && !mbusy(cyc - 1)) begin
      v       = int'(value_m);
      have    = 1;
      copy_c  = cyc;
      start_c = cyc + v / 100 + (v / 10) % 10 + 1;
      end_c   = start_c + 50 * CPB;
      ln[0]   = 8'(8'h30 + v / 100);
      ln[1]   = 8'(8'h30 + (v / 10) % 10);
      ln[2]   = 8'(8'h30 + v % 10);
      ln[3]   = 8'h0D;
      ln[4]   = 8'h0A;
    end
  end

  int n_cp = 0, cp_cyc = 0, fd_main = 0, fd_def = 0;
  int fall_main = 0, fall_def = 0;

  initial forever begin
    logic e_tx, e_b, e_c, e_f;
    @(negedge clk);
    if (rst) begin
      e_tx = 1'b1; e_b = 1'b0; e_c = 1'b0; e_f = 1'b0;
    end else begin
      e_c  = have && cyc == copy_c;
      e_b  = mbusy(cyc);
      e_f  = have && cyc == end_c;
      e_tx = (have && cyc >= start_c && cyc < end_c) ? line_bit(cyc - start_c) : 1'b1;
    end
    chk1($sformatf("model uart_tx c%0d", cyc), tx_m, e_tx);
    chk1($sformatf("model busy c%0d", cyc), busy_m, e_b);
    chk1($sformatf("model bpm_copied c%0d", cyc), copied_m, e_c);
    chk1($sformatf("model frame_done c%0d", cyc), fd_m, e_f);
    if (copied_m) begin n_cp++; cp_cyc = cyc; end
    if (fd_m) fd_main = cyc;
    if (fd_d) fd_def = cyc;
  end

  // ---------------- helpers ----------------------------------------------
  function automatic logic txl(input bit d);
    return d ? tx_d : tx_m;
  endfunction

  task automatic offer(input bit d, input logic [7:0] v);
    bit got = 0;
    if (d) begin value_d = v; valid_d = 1'b1; end
    else   begin value_m = v; valid_m = 1'b1; end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (d ? copied_d : copied_m) begin got = 1; break; end
    end
    chk1($sformatf("ack_seen %0d", v), got, 1'b1);
    @(posedge clk);
    #1;
    if (d) valid_d = 1'b0; else valid_m = 1'b0;
  endtask

  // Independent UART receiver: samples each bit at its centre.
  task automatic get_line(input bit d, input int cpb, input string digits);
    logic [7:0] exp_b [5];
    logic [7:0] by;
    bit         found;
    exp_b[0] = digits[0];
    exp_b[1] = digits[1];
    exp_b[2] = digits[2];
    exp_b[3] = 8'h0D;
    exp_b[4] = 8'h0A;
    for (int i = 0; i < 5; i++) begin
      found = 0;
      for (int w = 0; w < 20 * cpb + 2000; w++) begin
        @(negedge clk);
        if (txl(d) == 1'b0) begin found = 1; break; end
      end
      chk1($sformatf("rx_start_seen %s[%0d]", digits, i), found, 1'b1);
      if (!found) return;
      if (i == 0) begin
        if (d) fall_def = cyc; else fall_main = cyc;
      end
      repeat (cpb / 2) @(negedge clk);
      chk1($sformatf("rx_start_bit %s[%0d]", digits, i), txl(d), 1'b0);
      for (int b = 0; b < 8; b++) begin
        repeat (cpb) @(negedge clk);
        by[b] = txl(d);
      end
      repeat (cpb) @(negedge clk);
      chk1($sformatf("rx_stop_bit %s[%0d]", digits, i), txl(d), 1'b1);
      chkn($sformatf("rx_byte %s[%0d]", digits, i), int'(by), int'(exp_b[i]));
    end
  endtask

  // ---------------- directed sequence ------------------------------------
  logic [7:0] bvals [8] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200, 8'd255};
  string      bstrs [8] = '{"000", "009", "010", "099", "100", "199", "200", "255"};

  initial begin
    int  n0;
    bit  found;

    repeat (3) @(posedge clk);
    #1;
    chk1("reset uart_tx", tx_m, 1'b1);
    chk1("reset busy", busy_m, 1'b0);
    chk1("reset bpm_copied", copied_m, 1'b0);
    chk1("reset frame_done", fd_m, 1'b0);
    rst = 1'b0;

    // Idle with no request.
    n0 = n_cp;
    repeat (1000) @(negedge clk);
    chkn("idle ack count", n_cp - n0, 0);
    chk1("idle uart_tx", tx_m, 1'b1);
    chk1("idle busy", busy_m, 1'b0);

    // 72: one acknowledge, 8 CONV cycles, 800-cycle line.
    n0 = n_cp;
    fork
      get_line(0, CPB, "072");
      offer(0, 8'd72);
    join
    repeat (20) @(negedge clk);
    chkn("72 ack count", n_cp - n0, 1);
    chkn("72 conv cycles", fall_main - cp_cyc, 8);
    chkn("72 frame length", fd_main - fall_main, 800);

    // Digit boundaries.
    for (int k = 0; k < 8; k++) begin
      fork
        get_line(0, CPB, bstrs[k]);
        offer(0, bvals[k]);
      join
      repeat (20) @(negedge clk);
    end

    // New value held while busy: acknowledged right after frame_done.
    n0 = n_cp;
    fork
      begin
        get_line(0, CPB, "200");
        get_line(0, CPB, "120");
      end
      begin
        offer(0, 8'd200);
        repeat (50) @(posedge clk);
        #1;
        offer(0, 8'd120);
        chkn("held ack after frame_done", cp_cyc - fd_main, 1);
      end
    join
    repeat (20) @(negedge clk);
    chkn("held ack count", n_cp - n0, 2);

    // en dropped during the tens digit.
    fork
      get_line(0, CPB, "035");
      begin
        offer(0, 8'd35);
        repeat (203) @(posedge clk);
        #1;
        en = 1'b0;
        value_m = 8'd88;
        valid_m = 1'b1;
      end
    join
    n0 = n_cp;
    repeat (300) @(negedge clk);
    chkn("no ack while en low", n_cp - n0, 0);
    chk1("idle while en low", busy_m, 1'b0);
    @(posedge clk);
    #1;
    en = 1'b1;
    fork
      get_line(0, CPB, "088");
      offer(0, 8'd88);
    join
    repeat (20) @(negedge clk);

    // Reset in the middle of a zero data bit.
    offer(0, 8'd147);
    found = 0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (tx_m == 1'b0) begin found = 1; break; end
    end
    chk1("rst test start bit seen", found, 1'b1);
    repeat (2 * CPB + 5) @(posedge clk);
    #1;
    chk1("tx low before rst", tx_m, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk1("async rst uart_tx", tx_m, 1'b1);
    chk1("async rst busy", busy_m, 1'b0);
    chk1("async rst bpm_copied", copied_m, 1'b0);
    chk1("async rst frame_done", fd_m, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    fork
      get_line(0, CPB, "060");
      offer(0, 8'd60);
    join
    repeat (20) @(negedge clk);

    // Default 868 cycles/bit instance: reset mid-bit, then one line.
    offer(1, 8'd147);
    found = 0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (tx_d == 1'b0) begin found = 1; break; end
    end
    chk1("def start bit seen", found, 1'b1);
    repeat (2 * CPB_D + 100) @(posedge clk);
    #1;
    chk1("def tx low before rst", tx_d, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk1("def async rst uart_tx", tx_d, 1'b1);
    chk1("def async rst busy", busy_d, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fork
      get_line(1, CPB_D, "060");
      offer(1, 8'd60);
    join
    repeat (500) @(negedge clk);
    chkn("def frame length", fd_def - fall_def, 50 * CPB_D);
    chk1("def idle busy", busy_d, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
